// File: rtl/wavegen_vca_if.sv
// wavegen_vca_if: sample/envelope bundle between wavegen_adsr, the VCA and the mixer.
// master drives the strobe and operands; slave (the VCA) returns the scaled sample.
`timescale 1ns/1ps
interface wavegen_vca_if #(
    parameter int SAMPLE_W = 16,
    parameter int ENV_W    = 8
);
    logic                       sample_strobe;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic        [ENV_W-1:0]    envelope_in;
    logic        [3:0]          level;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       out_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output sample_strobe,
        output sample_in,
        output envelope_in,
        output level,
        input  sample_out,
        input  out_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  sample_strobe,
        input  sample_in,
        input  envelope_in,
        input  level,
        output sample_out,
        output out_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/wavegen_vca.sv
// wavegen_vca: serial shift-add VCA, sample x envelope then x channel level.
// Optional WAVEGEN_VCA_SMOOTH_EN slews the envelope by at most 16 per sample.
`timescale 1ns/1ps
module wavegen_vca #(
    parameter int SAMPLE_W = 16,
    parameter int ENV_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    wavegen_vca_if.slave  bus
);

    localparam int ACC_W     = SAMPLE_W + ENV_W + 1;
    localparam int LVL_SHIFT = 4;

    localparam logic [3:0]     ENV_LAST  = 4'(ENV_W);
    localparam logic [3:0]     LVL_LAST  = 4'(LVL_SHIFT);
    localparam logic [ENV_W:0] ENV_UNITY = {1'b1, {ENV_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL_ENV,
        MUL_LVL,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                       busy_c;
    logic                       done_c;
    logic                       accept;

    logic [3:0]                 cnt;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    mcand;
    logic        [ENV_W:0]      mplier;
    logic        [3:0]          lvl_q;
    logic signed [SAMPLE_W-1:0] result;

    logic signed [ACC_W-1:0]    partial;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    sample_ext;
    logic signed [SAMPLE_W-1:0] p1;
    logic signed [ACC_W-1:0]    p1_ext;
    logic signed [SAMPLE_W-1:0] p2;
    logic        [4:0]          lvl_mult;

    logic        [ENV_W-1:0]    env_src;
    logic        [ENV_W:0]      env_mult;

    logic signed [SAMPLE_W-1:0] sample_out_q;
    logic                       out_valid_q;
    logic                       overrun_q;

    assign accept = (state == IDLE) && bus.sample_strobe;

`ifdef WAVEGEN_VCA_SMOOTH_EN
    localparam logic [ENV_W-1:0] SMOOTH_STEP = ENV_W'(16);

    logic [ENV_W-1:0] env_smooth;
    logic [ENV_W-1:0] env_step;

    // Slew-limited envelope: move toward the target by at most SMOOTH_STEP.
    always_comb begin
        env_step = bus.envelope_in;
        if (bus.envelope_in > env_smooth) begin
            if ((bus.envelope_in - env_smooth) > SMOOTH_STEP) begin
                env_step = env_smooth + SMOOTH_STEP;
            end
        end else begin
            if ((env_smooth - bus.envelope_in) > SMOOTH_STEP) begin
                env_step = env_smooth - SMOOTH_STEP;
            end
        end
    end

    // Smoothed envelope only advances on accepted strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            env_smooth <= '0;
        end else if (accept) begin
            env_smooth <= env_step;
        end
    end

    assign env_src = env_step;
`else
    assign env_src = bus.envelope_in;
`endif

    // Full-scale envelope maps to 256 so unity gain is exact.
    assign env_mult = (env_src == {ENV_W{1'b1}}) ? ENV_UNITY
                                                 : {1'b0, env_src};

    assign sample_ext = {{(ACC_W-SAMPLE_W){bus.sample_in[SAMPLE_W-1]}},
                         bus.sample_in};
    assign partial    = mplier[0] ? mcand : '0;
    assign sum        = acc + partial;
    assign p1         = sum[SAMPLE_W+ENV_W-1:ENV_W];
    assign p1_ext     = {{(ACC_W-SAMPLE_W){p1[SAMPLE_W-1]}}, p1};
    assign p2         = sum[SAMPLE_W+LVL_SHIFT-1:LVL_SHIFT];
    assign lvl_mult   = {1'b0, lvl_q} + 5'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fixed 9 + 5 step multiply, no early-out.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.sample_strobe) begin
                    state_nxt = MUL_ENV;
                end
            end
            MUL_ENV: begin
                if (cnt == ENV_LAST) begin
                    state_nxt = MUL_LVL;
                end
            end
            MUL_LVL: begin
                if (cnt == LVL_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
            end
            MUL_ENV, MUL_LVL: begin
                busy_c = 1'b1;
            end
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
        endcase
    end

    // Shift-add datapath shared by the envelope and level passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            lvl_q  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= '0;
                        mcand  <= sample_ext;
                        mplier <= env_mult;
                        lvl_q  <= bus.level;
                        cnt    <= '0;
                    end
                end
                MUL_ENV: begin
                    if (cnt == ENV_LAST) begin
                        acc    <= '0;
                        mcand  <= p1_ext;
                        mplier <= (ENV_W+1)'(lvl_mult);
                        cnt    <= '0;
                    end else begin
                        acc    <= sum;
                        mcand  <= mcand <<< 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 4'd1;
                    end
                end
                MUL_LVL: begin
                    if (cnt == LVL_LAST) begin
                        result <= p2;
                        cnt    <= '0;
                    end else begin
                        acc    <= sum;
                        mcand  <= mcand <<< 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Registered result, completion pulse and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            out_valid_q <= done_c;
            overrun_q   <= bus.sample_strobe && busy_c;
            if (done_c) begin
                sample_out_q <= result;
            end
        end
    end

    assign bus.sample_out = sample_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy_c;

endmodule

// File: tb/tb_wavegen_vca.sv
// tb_wavegen_vca: random + directed stimulus against an arithmetic VCA model.
// Compile with WAVEGEN_VCA_SMOOTH_EN to match the smoothed build.
`timescale 1ns/1ps
module tb_wavegen_vca;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    wavegen_vca_if #(.SAMPLE_W(16), .ENV_W(8)) vif ();

    wavegen_vca #(
        .SAMPLE_W (16),
        .ENV_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int env_s    = 0;
    int last_out = 0;

    task automatic check(string tag, logic signed [31:0] got, int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int vca_model(int s, int e, int l);
        longint gain;
        longint p1;
        gain = (e == 255) ? 256 : e;
        p1   = fdiv(longint'(s) * gain, 256);
        return int'(fdiv(p1 * (l + 1), 16));
    endfunction

    function automatic int slew(int cur, int tgt);
        if (tgt > cur) return cur + ((tgt - cur > 16) ? 16 : tgt - cur);
        return cur - ((cur - tgt > 16) ? 16 : cur - tgt);
    endfunction

    function automatic int env_for(int e);
`ifdef WAVEGEN_VCA_SMOOTH_EN
        env_s = slew(env_s, e);
        return env_s;
`else
        return e;
`endif
    endfunction

    task automatic put(bit stb, int s, int e, int l);
        vif.sample_strobe = stb;
        vif.sample_in     = 16'(s);
        vif.envelope_in   = 8'(e);
        vif.level         = 4'(l);
    endtask

    task automatic scramble();
        put(1'b0, int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    endtask

    task automatic run_one(int s, int e, int l);
        int exp_v;
        exp_v = vca_model(s, env_for(e), l);
        put(1'b1, s, e, l);
        @(posedge clk);
        #1;
        scramble();
        check("busy_start", vif.busy, 1);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (k < 15) begin
                check("busy_run", vif.busy, 1);
                check("valid_early", vif.out_valid, 0);
            end else begin
                check("busy_end", vif.busy, 0);
                check("valid_n15", vif.out_valid, 1);
                check("sample_out", vif.sample_out, exp_v);
                last_out = int'(vif.sample_out);
            end
        end
        @(posedge clk);
        #1;
        check("valid_pulse", vif.out_valid, 0);
        check("sample_hold", vif.sample_out, exp_v);
    endtask

    task automatic run_overrun(int s, int e, int l);
        int  exp_v;
        bit  stb;
        exp_v = vca_model(s, env_for(e), l);
        put(1'b1, s, e, l);
        @(posedge clk);
        #1;
        scramble();
        for (int k = 1; k <= 20; k++) begin
            stb = (k == 5 || k == 15);
            if (stb) begin
                put(1'b1, int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
            end
            @(posedge clk);
            #1;
            vif.sample_strobe = 1'b0;
            check("ovr_overrun", vif.overrun, int'(stb));
            check("ovr_valid", vif.out_valid, int'(k == 15));
            check("ovr_busy", vif.busy, int'(k < 15));
            if (k == 15) check("ovr_result", vif.sample_out, exp_v);
        end
    endtask

    task automatic run_reset_mid(int s, int e, int l);
        void'(env_for(e));
        put(1'b1, s, e, l);
        @(posedge clk);
        #1;
        scramble();
        for (int k = 1; k <= 20; k++) begin
            rst = (k == 7);
            @(posedge clk);
            #1;
            rst = 1'b0;
            if (k >= 7) begin
                check("rstmid_busy", vif.busy, 0);
                check("rstmid_valid", vif.out_valid, 0);
                check("rstmid_out", vif.sample_out, 0);
            end
        end
        env_s = 0;
    endtask

    initial begin
        int s;
        int e;
        int l;
        int pick;
        rst = 1'b1;
        put(1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", vif.sample_out, 0);
        check("rst_valid", vif.out_valid, 0);
        check("rst_busy", vif.busy, 0);
        check("rst_overrun", vif.overrun, 0);
        rst = 1'b0;
        env_s = 0;

        for (int i = 0; i < 13; i++) begin
            run_one(25600, 200, 15);
`ifdef WAVEGEN_VCA_SMOOTH_EN
            check("smooth_step", last_out, (i < 12) ? 1600 * (i + 1) : 20000);
`else
            check("nosmooth", last_out, 20000);
`endif
        end

        run_one(16384, 128, 15);
        run_one(-32768, 255, 15);
        run_one(32767, 255, 15);
        run_one(1000, 64, 7);
        run_one(-3, 1, 0);
        run_one(1234, 0, 9);
`ifndef WAVEGEN_VCA_SMOOTH_EN
        check("env0_zero", last_out, 0);
        run_one(16384, 128, 15);
        check("tp_8192", last_out, 8192);
        run_one(-32768, 255, 15);
        check("tp_neg_unity", last_out, -32768);
        run_one(1000, 64, 7);
        check("tp_125", last_out, 125);
        run_one(-3, 1, 0);
        check("tp_floor", last_out, -1);
`endif

        run_overrun(12000, 150, 11);
        repeat (2) @(posedge clk);
        #1;
        run_one(-20000, 90, 4);

        run_reset_mid(30000, 250, 15);
        run_one(-7777, 33, 13);

        for (int i = 0; i < 60; i++) begin
            s = int'($urandom_range(0, 65535)) - 32768;
            pick = int'($urandom_range(0, 7));
            case (pick)
                0: e = 0;
                1: e = 1;
                2: e = 254;
                3: e = 255;
                default: e = int'($urandom_range(0, 255));
            endcase
            l = int'($urandom_range(0, 15));
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
            run_one(s, e, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wavegen_vca.md
Name: wavegen_vca

Overview:
- Voltage-controlled amplifier stage directly downstream of wavegen_adsr.
- Scales one signed oscillator sample per sample_strobe by the 8-bit ADSR envelope, then by a 4-bit channel level.
- Feeds the channel mixer.
- Uses a serial shift-add multiplier: one 16-bit datapath, fixed latency well inside the 1024-clock sample period.

Parameters:
- SAMPLE_W, 16, width of signed sample_in / sample_out.
- ENV_W, 8, width of unsigned envelope_in (fixed at 8; other values unsupported).

Ports:
- clk  in  1  system clock (49.152 MHz).
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- sample_strobe  in  1  one-cycle pulse per output sample (48 kHz).
- sample_in  in  SAMPLE_W  signed oscillator sample, captured on strobe.
- envelope_in  in  8  unsigned envelope from wavegen_adsr, captured on strobe.
- level  in  4  channel volume, captured on strobe; 15 = unity.
- sample_out  out  SAMPLE_W  signed scaled sample, held between updates.
- out_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high while a multiply is in progress.
- overrun  out  1  one-cycle pulse when a strobe arrives while busy.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; sample_out=0, out_valid=0, busy=0, overrun=0; internal accumulators/counters cleared.
- Reset mid-operation aborts the multiply. No out_valid is produced for the aborted sample.
- States: IDLE -> MUL_ENV -> MUL_LVL -> DONE -> IDLE.
- IDLE:
  - On sample_strobe=1, capture sample_in, envelope_in and level into registers.
  - Effective env multiplier E = 256 if envelope_in==255, else envelope_in (9-bit unsigned, so 255 is exact unity).
  - Go to MUL_ENV; busy=1 from the next cycle.
- MUL_ENV, 9 cycles:
  - Shift-add, LSB first, of sign-extended sample x E into a 25-bit signed accumulator.
  - Then P1 = acc >>> 8 (arithmetic shift, floor toward -inf), truncated to SAMPLE_W. No overflow is possible.
- MUL_LVL, 5 cycles:
  - Shift-add of P1 x (level+1) (5-bit, 1..16) into a 21-bit signed accumulator.
  - Then P2 = acc >>> 4 (floor).
- DONE, 1 cycle:
  - sample_out <= P2, out_valid <= 1, busy <= 0; return to IDLE.
- Latency: strobe sampled at edge N -> sample_out/out_valid valid after edge N+15. This is fixed, including for envelope 0 and level 0; no early-out.
- out_valid is high for exactly one cycle. sample_out is held until the next DONE.
- Strobe while busy (states MUL_ENV..DONE): ignored, with no effect on the in-flight result; overrun pulses high for 1 cycle after that edge.
- Strobe in the same cycle as the DONE->IDLE transition is ignored (busy still high) and flagged as overrun.
- Input changes outside the strobe cycle have no effect.
- Output range: |sample_out| <= |sample_in|. -32768 x unity x unity = -32768.

Optional Feature:
- Macro WAVEGEN_VCA_SMOOTH_EN.
- Defined:
  - An 8-bit env_smooth register (reset 0) replaces envelope_in as the multiplier source.
  - On each accepted strobe, before capture, env_smooth moves toward envelope_in by min(|diff|,16), then is used for that sample.
  - The 255->unity rule applies to env_smooth.
  - Purpose: removes zipper noise on abrupt gate/retrigger envelope steps.
- Undefined: envelope_in is captured directly. No extra registers or logic.

Test Plan:
- sample_in=16384, envelope_in=128, level=15, strobe at N -> sample_out=8192 and a single out_valid pulse after edge N+15; busy high for edges N+1..N+14.
- sample_in=-32768 and 32767, envelope_in=255, level=15 -> sample_out=-32768 and 32767 exactly (unity path, no overflow).
- sample_in=1000, envelope_in=64, level=7 -> P1=250, sample_out=125. sample_in=-3, envelope_in=1, level=0 -> sample_out=-1 (floor rounding). envelope_in=0 -> sample_out=0 at N+15.
- Strobes at N and N+5 -> only one out_valid (N+15) carrying the first sample's result; overrun pulse after edge N+5. A strobe at N+20 is processed normally.
- rst asserted at N+7 for 1 cycle -> sample_out=0, no out_valid, busy=0. Strobe at N+30 -> correct result at N+45.
- With WAVEGEN_VCA_SMOOTH_EN: envelope_in steps 0->200, sample_in=25600, level=15 -> successive outputs use env 16,32,...,192,200, giving sample_out 1600,3200,...,19200,20000. Without the macro the first output is 20000.
